dff_bank_arbiter: RTL and testbench
===================================

Name: dff_bank_arbiter

Overview:
- Round-robin arbiter that shares one WIDTH-bit enable-gated D register among NREQ requesters.
- Sequences ownership, generates the register enable and selects the data source.
- Supports bounded multi-cycle locked ownership for back-to-back writes.
- Sits between requesting control units and the shared storage flop; q/qbar feed downstream logic.

Parameters:
NREQ, 4, number of requesters (2..8; pointer wraps mod NREQ)
WIDTH, 8, data/register width
MAX_HOLD, 4, maximum consecutive grant cycles per ownership (>=1)
IDXW, 2, width of owner index, must equal clog2(NREQ)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
req  input  NREQ  per-requester write request, level; held until granted
lock  input  NREQ  per-requester request to keep ownership next cycle
din  input  NREQ*WIDTH  requester data, slice i = din[i*WIDTH +: WIDTH]
gnt  output  NREQ  registered one-hot grant, all-zero when idle
owner  output  IDXW  index of current/last owner
q  output  WIDTH  shared register value
qbar  output  WIDTH  bitwise inverse of q
wr_done  output  1  registered pulse, high the cycle after q was written

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately, including mid-ownership):
  - state=IDLE, gnt=0, owner=0, ptr=0, hold_cnt=0
  - q=0, qbar=all ones, wr_done=0
- Internal write enable: wr_en = |(gnt & req). On a clock edge with wr_en=1, q <= din slice[owner] and wr_done <= 1; otherwise q holds and wr_done <= 0.
- qbar is always ~q, with no extra latency.
- Round-robin selection: search starts at index ptr and ascends mod NREQ; the first asserted req wins. On each new grant to index i, ptr <= (i+1) mod NREQ, so the last winner has lowest priority next time.
- State IDLE (gnt=0):
  - If any req is asserted at the edge: gnt <= onehot(winner), owner <= winner, hold_cnt <= 1, go to OWN.
  - Otherwise stay in IDLE.
- State OWN (gnt = onehot(owner)):
  - Keep ownership if req[owner] & lock[owner] & (hold_cnt < MAX_HOLD): gnt unchanged, hold_cnt++.
  - Otherwise release:
    - If any req is asserted (the owner's req is included, at lowest priority), grant the winner directly with no idle bubble. Set hold_cnt <= 1 and stay in OWN.
    - If no req is asserted: gnt <= 0, go to IDLE. owner keeps the last value.
- Latency: req rises before edge k -> gnt at edge k -> q updated at edge k+1 -> wr_done high during cycle after k+1.
- Single-cycle ownership (lock=0) yields exactly one write per grant.
- Owner drops req while granted: no write that cycle (wr_en=0); release at that edge.
- MAX_HOLD=1 disables locking; every grant lasts one cycle.
- lock without req is ignored. lock of a non-owner has no effect.
- Changes to the din of non-owners never affect q.
- gnt is never multi-hot; gnt and owner change only at clock edges.

Test Plan:
- Reset: drive rst=0 with req=4'b1111 -> gnt=0, q=8'h00, qbar=8'hFF, wr_done=0. Release rst: first grant goes to req0.
- Single requester: req=4'b0100, din2=8'hA5, lock=0.
  - gnt=4'b0100 one edge later; q=8'hA5 and wr_done=1 the next cycle.
  - gnt returns to 0 if req2 is dropped after its grant cycle.
- Round-robin fairness: req=4'b1111, lock=0 held for 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,... with no idle cycles; q tracks din of each owner.
- Lock limit: MAX_HOLD=4, req=4'b0011, lock=4'b0001 -> gnt=0001 for exactly 4 cycles (4 writes), then 0010. req0 is granted again only after req1's turn.
- Owner drop mid-lock: req0 and lock0 granted, then req0 deasserted in cycle 2 -> no write that cycle; grant moves to a pending requester, or to IDLE with q unchanged.
- Reset mid-ownership: assert rst=0 between clock edges during a locked burst -> gnt=0 and q=0 immediately. After release, arbitration restarts with ptr=0.

Source files
------------

// File: rtl/dff_bank_arbiter.sv
// Round-robin owner sequencing for one shared enable-gated register.
// Owners may lock for up to MAX_HOLD consecutive grant cycles.
module dff_bank_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4,
  parameter int IDXW     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       lock,
  input  logic [NREQ*WIDTH-1:0] din,
  output logic [NREQ-1:0]       gnt,
  output logic [IDXW-1:0]       owner,
  output logic [WIDTH-1:0]      q,
  output logic [WIDTH-1:0]      qbar,
  output logic                  wr_done
);

  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic {
    S_IDLE,
    S_OWN
  } state_e;

  state_e           state_q;
  logic [NREQ-1:0]  gnt_q;
  logic [IDXW-1:0]  owner_q;
  logic [IDXW-1:0]  ptr_q;
  logic [HW-1:0]    hold_q;
  logic [WIDTH-1:0] data_q;
  logic             wr_done_q;

  logic [IDXW-1:0]  win_hi;
  logic [IDXW-1:0]  win_lo;
  logic             hit_hi;
  logic             hit_lo;
  logic [IDXW-1:0]  winner;
  logic [IDXW-1:0]  ptr_d;
  logic [NREQ-1:0]  gnt_d;
  logic             any_req;
  logic             keep;
  logic             wr_en;
  logic [WIDTH-1:0] wdata;

  // Lowest index at/above ptr wins; else lowest index overall (wrap).
  always_comb begin
    win_hi = '0;
    win_lo = '0;
    hit_hi = 1'b0;
    hit_lo = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_lo = IDXW'(i);
        hit_lo = 1'b1;
        if (IDXW'(i) >= ptr_q) begin
          win_hi = IDXW'(i);
          hit_hi = 1'b1;
        end
      end
    end
  end

  assign winner  = hit_hi ? win_hi : win_lo;
  assign any_req = hit_lo;
  assign gnt_d   = NREQ'(1) << winner;

  assign ptr_d = (winner == IDXW'(NREQ - 1))
               ? '0
               : winner + 1'b1;

  assign keep = req[owner_q]
              & lock[owner_q]
              & (hold_q < HW'(MAX_HOLD));

  assign wr_en = |(gnt_q & req);

  always_comb begin
    wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == IDXW'(i)) begin
        wdata = din[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      data_q    <= '0;
      wr_done_q <= 1'b0;
    end else begin
      wr_done_q <= wr_en;
      if (wr_en) begin
        data_q <= wdata;
      end
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            gnt_q   <= gnt_d;
            owner_q <= winner;
            ptr_q   <= ptr_d;
            hold_q  <= HW'(1);
            state_q <= S_OWN;
          end
        end
        S_OWN: begin
          if (keep) begin
            hold_q <= hold_q + 1'b1;
          end else if (any_req) begin
            gnt_q   <= gnt_d;
            owner_q <= winner;
            ptr_q   <= ptr_d;
            hold_q  <= HW'(1);
          end else begin
            gnt_q   <= '0;
            hold_q  <= '0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          gnt_q   <= '0;
          hold_q  <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign owner   = owner_q;
  assign q       = data_q;
  assign qbar    = ~data_q;
  assign wr_done = wr_done_q;

  a_gnt_onehot: assert property (
    @(posedge clk) disable iff (!rst) $onehot0(gnt_q)
  );

  a_hold_bound: assert property (
    @(posedge clk) disable iff (!rst) hold_q <= HW'(MAX_HOLD)
  );

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Random and directed stimulus against an index-level arbiter model.
// Outputs are compared on the falling clock edge.
module tb_dff_bank_arbiter;

  localparam int NREQ     = 4;
  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 4;
  localparam int IDXW     = 2;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       lock;
  logic [NREQ*WIDTH-1:0] din;
  logic [NREQ-1:0]       gnt;
  logic [IDXW-1:0]       owner;
  logic [WIDTH-1:0]      q;
  logic [WIDTH-1:0]      qbar;
  logic                  wr_done;

  int n_chk;
  int n_fail;

  // model: owner index or -1 when idle
  int         m_own;
  int         m_last;
  int         m_ptr;
  int         m_held;
  logic [7:0] m_q;
  logic       m_wd;

  dff_bank_arbiter #(
    .NREQ    (NREQ),
    .WIDTH   (WIDTH),
    .MAX_HOLD(MAX_HOLD),
    .IDXW    (IDXW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .lock   (lock),
    .din    (din),
    .gnt    (gnt),
    .owner  (owner),
    .q      (q),
    .qbar   (qbar),
    .wr_done(wr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               tag, obs, exp, $time);
    end
  endtask

  function automatic int pick();
    int idx;
    for (int k = 0; k < NREQ; k++) begin
      idx = (m_ptr + k) % NREQ;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_own  = -1;
    m_last = 0;
    m_ptr  = 0;
    m_held = 0;
    m_q    = '0;
    m_wd   = 1'b0;
  endtask

  task automatic model_step();
    int w;
    if (m_own >= 0 && req[m_own]) begin
      m_q  = din[m_own*WIDTH +: WIDTH];
      m_wd = 1'b1;
    end else begin
      m_wd = 1'b0;
    end
    if (m_own >= 0 && req[m_own] && lock[m_own]
        && m_held < MAX_HOLD) begin
      m_held++;
    end else begin
      w = pick();
      if (w >= 0) begin
        m_own  = w;
        m_last = w;
        m_held = 1;
        m_ptr  = (w + 1) % NREQ;
      end else begin
        m_own = -1;
      end
    end
  endtask

  task automatic check_all();
    logic [NREQ-1:0] eg;
    logic [7:0]      eqb;
    eg  = '0;
    if (m_own >= 0) eg[m_own] = 1'b1;
    eqb = ~m_q;
    chk("gnt", gnt, eg);
    chk("owner", owner, m_last);
    chk("q", q, m_q);
    chk("qbar", qbar, eqb);
    chk("wr_done", wr_done, m_wd);
  endtask

  // entered and left at a falling edge
  task automatic step(input logic [NREQ-1:0] r,
                      input logic [NREQ-1:0] l,
                      input logic [31:0] d);
    req  = r;
    lock = l;
    din  = d;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic mid_reset();
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("rst_gnt", gnt, 0);
    chk("rst_q", q, 0);
    chk("rst_qbar", qbar, 8'hFF);
    chk("rst_wd", wr_done, 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [NREQ-1:0] lk [6];
    logic [NREQ-1:0] ex [6];
    logic [NREQ-1:0] r;
    logic [NREQ-1:0] l;
    n_chk  = 0;
    n_fail = 0;
    model_reset();
    req  = 4'b1111;
    lock = '0;
    din  = $urandom;
    rst  = 1'b1;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_gnt", gnt, 0);
    chk("reset_q", q, 0);
    chk("reset_qbar", qbar, 8'hFF);
    chk("reset_wd", wr_done, 0);
    check_all();
    rst = 1'b1;

    step(4'b1111, 4'b0000, $urandom);
    chk("first_gnt", gnt, 4'b0001);

    for (int k = 0; k < 8; k++) begin
      step(4'b1111, 4'b0000, $urandom);
      chk("rr_gnt", gnt, 4'b0001 << ((k + 1) % 4));
    end

    step(4'b0100, 4'b0000, {8'h3C, 8'hA5, 16'h5AC3});
    chk("single_gnt", gnt, 4'b0100);
    step(4'b0100, 4'b0000, {8'h11, 8'hA5, 16'h2233});
    chk("single_q", q, 8'hA5);
    chk("single_wd", wr_done, 1);
    step(4'b0000, 4'b0000, $urandom);
    chk("single_idle", gnt, 0);
    chk("single_hold", q, 8'hA5);

    ex = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001};
    for (int k = 0; k < 6; k++) begin
      step(4'b0011, 4'b0001, $urandom);
      chk("lock_gnt", gnt, ex[k]);
    end

    step(4'b0001, 4'b0001, $urandom);
    chk("drop_keep", gnt, 4'b0001);
    step(4'b0000, 4'b0001, $urandom);
    chk("drop_idle", gnt, 0);
    chk("drop_wd", wr_done, 0);

    repeat (3) step(4'b0011, 4'b0011, $urandom);
    mid_reset();
    step(4'b1111, 4'b0000, $urandom);
    chk("post_rst_gnt", gnt, 4'b0001);

    lk = '{4'hF, 4'hF, 4'h0, 4'h5, 4'hA, 4'h3};
    for (int k = 0; k < 500; k++) begin
      r = NREQ'($urandom);
      l = lk[$urandom_range(5)];
      if ($urandom_range(7) == 0) l = NREQ'($urandom);
      step(r, l, $urandom);
      if ($urandom_range(60) == 0) mid_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
